div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative 32-bit RISC-V M-extension divider for the execute stage.
- Runs alongside the single-cycle ALU: the ALU covers add/sub/shift/compare/logic, and this block covers DIV/DIVU/REM/REMU.
- The pipeline stalls on busy_o and captures result_o when valid_o pulses.
- Uses radix-2 restoring division, one quotient bit per cycle, with a fast path for special cases.

Parameters:
- Width, 32, operand/result width; the counter is $clog2(Width)+1 bits wide.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- start_i  input  1  request; accepted only in IDLE.
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
- DataA  input  Width  dividend; sampled with start_i.
- DataB  input  Width  divisor; sampled with start_i.
- flush_i  input  1  abort the current operation (branch mispredict or trap).
- busy_o  output  1  high in any state other than IDLE.
- valid_o  output  1  one-cycle pulse; result_o is valid this cycle.
- result_o  output  Width  quotient or remainder; held until the next accept.

Behaviour:
- Reset (asynchronous, rst_i=1): state=IDLE; busy_o=0; valid_o=0; result_o=0; counter=0; all internal registers cleared.
- States are IDLE, CALC, FIX, DONE.
- IDLE, start_i=1 and flush_i=0 at cycle N:
  - Latch the op, signs and operands.
  - Signed ops (DIV/REM) take the absolute values of both operands.
  - Divisor==0: go to DONE. Result is all ones for DIV/DIVU and DataA for REM/REMU.
  - Signed op, DataA==0x80000000, DataB==0xFFFFFFFF: go to DONE. Result is 0x80000000 for DIV and 0 for REM.
  - Otherwise go to CALC with counter=Width, remainder=0, quotient=|dividend|.
- CALC, one cycle per bit:
  - Shift {rem,quot} left by 1 and trial-subtract the divisor from rem.
  - If the difference is non-negative, rem=difference and quotient LSB=1; else quotient LSB=0.
  - Decrement the counter; when it reaches 0, go to FIX.
  - CALC occupies cycles N+1..N+32.
- FIX (cycle N+33):
  - Negate the quotient if the signs of A and B differed (DIV only).
  - Negate the remainder if A was negative (REM only); the remainder sign follows the dividend.
  - Load result_o and go to DONE.
- DONE: valid_o=1 for exactly one cycle, then IDLE.
  - Normal latency: start at N, valid_o at N+34.
  - Special-case latency: valid_o at N+1.
- busy_o=1 in CALC, FIX and DONE. The pipeline may issue a new start_i in the cycle after valid_o.
- start_i while busy_o=1: ignored; operands are not re-latched.
- flush_i=1 in any state: next state IDLE, no valid_o pulse, result_o unchanged. If flush_i and start_i are both high in IDLE, flush wins and nothing is accepted.
- flush_i in the DONE cycle: the valid_o pulse of that cycle still appears (combinational from state). The pipeline discards it.
- Reset asserted mid-operation: immediate return to IDLE; outputs take their reset values.
- All arithmetic is unsigned on magnitudes, with a Width+1-bit trial subtraction. |0x80000000| is handled as unsigned 0x80000000 with no overflow.

Decomposition:
- Shared package:
  - The op_i encoding constants (DIV/DIVU/REM/REMU), next to the ALU select encodings.
  - An enum typedef for the state.
  - A constant for the divide-by-zero quotient (all ones).
- One natural sub-module: div_step. It is combinational and computes one restoring iteration: inputs rem, quot, divisor; outputs next rem, next quot.

Test Plan:
- DIV 20/3, start at N -> busy_o=1 N+1..N+34; valid_o at N+34 with result_o=6. REM 20/3 -> result_o=2.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 0xFFFFFFF9/2 -> 1; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Divide by zero:
  - DIVU 5/0 -> valid_o at N+1, result_o=0xFFFFFFFF.
  - REM 5/0 -> result_o=5.
- Signed overflow:
  - DIV 0x80000000/0xFFFFFFFF -> valid_o at N+1, result_o=0x80000000.
  - REM of the same operands -> 0.
- flush_i at N+10 during DIV 100/7 -> IDLE at N+11, no valid_o. A new DIV 9/3 started afterwards -> 3.
- start_i pulsed at N+5 with different operands during DIV 20/3 -> ignored, result_o=6. rst_i at N+15 of another op -> busy_o=0, result_o=0 immediately.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared execute-stage encodings: ALU selects, divider op codes, divider FSM states.
package div_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_sel_e;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // Wide enough for any supported Width; callers truncate to their own width.
    localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] i_rem,
    input  logic [Width-1:0] i_quot,
    input  logic [Width-1:0] i_divisor,
    output logic [Width-1:0] o_rem,
    output logic [Width-1:0] o_quot
);

    logic [Width:0] w_shiftRem;
    logic           w_fits;

    // The shifted remainder needs Width+1 bits; once the divisor fits, the
    // difference is below the divisor, so a Width-bit subtract is exact.
    assign w_shiftRem = {i_rem, i_quot[Width-1]};
    assign w_fits     = (w_shiftRem >= {1'b0, i_divisor});
    assign o_rem      = w_fits ? (w_shiftRem[Width-1:0] - i_divisor) : w_shiftRem[Width-1:0];
    assign o_quot     = {i_quot[Width-2:0], w_fits};

endmodule

// File: rtl/div_unit.sv
// Iterative RISC-V M-extension divider (DIV/DIVU/REM/REMU) with a fast path
// for divide-by-zero and signed overflow.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] DataA,
    input  logic [Width-1:0] DataB,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [Width-1:0] result_o
);

    localparam int CntW = $clog2(Width) + 1;
    localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

    div_state_e       r_state;
    div_state_e       w_nextState;
    logic [Width-1:0] r_rem;
    logic [Width-1:0] r_quot;
    logic [Width-1:0] r_divisor;
    logic [Width-1:0] r_result;
    logic [CntW-1:0]  r_count;
    logic             r_isRem;
    logic             r_negQ;
    logic             r_negR;

    logic             w_signed;
    logic             w_isRem;
    logic             w_aNeg;
    logic             w_bNeg;
    logic [Width-1:0] w_absA;
    logic [Width-1:0] w_absB;
    logic             w_divZero;
    logic             w_overflow;
    logic             w_special;
    logic [Width-1:0] w_specialRes;
    logic [Width-1:0] w_fixRes;
    logic [Width-1:0] w_stepRem;
    logic [Width-1:0] w_stepQuot;
    logic             w_accept;

    assign w_signed   = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_REM);
    assign w_isRem    = !((op_i == DIV_OP_DIV) || (op_i == DIV_OP_DIVU) || (op_i != DIV_OP_REMU && op_i != DIV_OP_REM));
    assign w_aNeg     = w_signed & DataA[Width-1];
    assign w_bNeg     = w_signed & DataB[Width-1];
    assign w_absA     = w_aNeg ? (Width'(0) - DataA) : DataA;
    assign w_absB     = w_bNeg ? (Width'(0) - DataB) : DataB;
    assign w_divZero  = (DataB == '0);
    assign w_overflow = w_signed && (DataA == MinNeg) && (DataB == '1);
    assign w_special  = w_divZero || w_overflow;
    assign w_accept   = (r_state == S_IDLE) && start_i && !flush_i;

    // Divide-by-zero wins over overflow; overflow only arises with a non-zero divisor anyway.
    assign w_specialRes = w_divZero ? (w_isRem ? DataA : Width'(DIV_ZERO_Q))
                                    : (w_isRem ? '0 : MinNeg);

    assign w_fixRes = r_isRem ? (r_negR ? (Width'(0) - r_rem)  : r_rem)
                              : (r_negQ ? (Width'(0) - r_quot) : r_quot);

    div_step #(
        .Width(Width)
    ) u_step (
        .i_rem     (r_rem),
        .i_quot    (r_quot),
        .i_divisor (r_divisor),
        .o_rem     (w_stepRem),
        .o_quot    (w_stepQuot)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_nextState = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == CntW'(1)) begin
                    w_nextState = S_FIX;
                end
            end
            S_FIX:   w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
        if (flush_i) begin
            w_nextState = S_IDLE;
        end
    end

    // A flush freezes the datapath so result_o keeps its last completed value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_count   <= '0;
            r_isRem   <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
        end else if (!flush_i) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_isRem   <= w_isRem;
                        r_negQ    <= w_aNeg ^ w_bNeg;
                        r_negR    <= w_aNeg;
                        r_divisor <= w_absB;
                        r_quot    <= w_absA;
                        r_rem     <= '0;
                        r_count   <= CntW'(Width);
                        if (w_special) begin
                            r_result <= w_specialRes;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_stepRem;
                    r_quot  <= w_stepQuot;
                    r_count <= r_count - CntW'(1);
                end
                S_FIX: begin
                    r_result <= w_fixRes;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o   = (r_state != S_IDLE);
    assign valid_o  = (r_state == S_DONE);
    assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: vector table plus hand-written
// sequences for flush, ignored start, mid-operation reset and fast-path corners.
module tb_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int NumVec = 18;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic        flush_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int          assertions;
    int          failures;
    logic [31:0] lastExp;
    vec_t        vecs [NumVec];

    div_unit #(
        .Width(32)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .DataA    (DataA),
        .DataB    (DataB),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Start one op, follow it cycle by cycle until valid_o, then check latency,
    // result, busy during the op and the return to idle afterwards.
    task automatic applyStimulus(input vec_t v);
        int   lat;
        logic busyOk;
        logic [31:0] res;
        @(negedge clk_i);
        op_i    = v.op;
        DataA   = v.a;
        DataB   = v.b;
        start_i = 1'b1;
        lat     = 0;
        busyOk  = 1'b1;
        res     = '0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk_i);
            if (c == 1) start_i = 1'b0;
            if (!busy_o) busyOk = 1'b0;
            if (valid_o) begin
                lat = c;
                res = result_o;
            end
        end
        checkOutput({v.name, "_latency"}, 32'(lat), 32'(v.lat));
        checkOutput({v.name, "_result"}, res, v.exp);
        checkOutput({v.name, "_busy"}, 32'(busyOk), 32'd1);
        @(negedge clk_i);
        checkOutput({v.name, "_idle_after"}, {30'd0, busy_o, valid_o}, 32'd0);
        lastExp = v.exp;
    endtask

    initial begin
        int   lat;
        logic sawValid;
        vec_t v;

        assertions = 0;
        failures   = 0;
        lastExp    = '0;
        rst_i      = 1'b1;
        start_i    = 1'b0;
        flush_i    = 1'b0;
        op_i       = OP_DIV;
        DataA      = '0;
        DataB      = '0;

        vecs[0]  = '{"div_20_3",        OP_DIV,  32'd20,        32'd3,         32'd6,         34};
        vecs[1]  = '{"rem_20_3",        OP_REM,  32'd20,        32'd3,         32'd2,         34};
        vecs[2]  = '{"div_m7_2",        OP_DIV,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  34};
        vecs[3]  = '{"rem_m7_2",        OP_REM,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  34};
        vecs[4]  = '{"remu_big_2",      OP_REMU, 32'hFFFFFFF9,  32'd2,         32'd1,         34};
        vecs[5]  = '{"divu_max_1",      OP_DIVU, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  34};
        vecs[6]  = '{"div_7_m2",        OP_DIV,  32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  34};
        vecs[7]  = '{"rem_7_m2",        OP_REM,  32'd7,         32'hFFFFFFFE,  32'd1,         34};
        vecs[8]  = '{"div_m8_m2",       OP_DIV,  32'hFFFFFFF8,  32'hFFFFFFFE,  32'd4,         34};
        vecs[9]  = '{"rem_m8_m3",       OP_REM,  32'hFFFFFFF8,  32'hFFFFFFFD,  32'hFFFFFFFE,  34};
        vecs[10] = '{"div_min_2",       OP_DIV,  32'h80000000,  32'd2,         32'hC0000000,  34};
        vecs[11] = '{"divu_min_max",    OP_DIVU, 32'h80000000,  32'hFFFFFFFF,  32'd0,         34};
        vecs[12] = '{"remu_min_max",    OP_REMU, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  34};
        vecs[13] = '{"div_0_5",         OP_DIV,  32'd0,         32'd5,         32'd0,         34};
        vecs[14] = '{"divu_5_0",        OP_DIVU, 32'd5,         32'd0,         32'hFFFFFFFF,  1};
        vecs[15] = '{"rem_5_0",         OP_REM,  32'd5,         32'd0,         32'd5,         1};
        vecs[16] = '{"div_ovf",         OP_DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1};
        vecs[17] = '{"rem_ovf",         OP_REM,  32'h80000000,  32'hFFFFFFFF,  32'd0,         1};

        repeat (2) @(negedge clk_i);
        checkOutput("reset_busy",   32'(busy_o),  32'd0);
        checkOutput("reset_valid",  32'(valid_o), 32'd0);
        checkOutput("reset_result", result_o,     32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < NumVec; i++) begin
            applyStimulus(vecs[i]);
        end

        // Flush during CALC: no pulse, result keeps the last completed value.
        @(negedge clk_i);
        op_i = OP_DIV; DataA = 32'd100; DataB = 32'd7; start_i = 1'b1;
        sawValid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (c == 1) start_i = 1'b0;
            if (c == 10) flush_i = 1'b1;
            if (c == 11) begin
                flush_i = 1'b0;
                checkOutput("flush_idle", 32'(busy_o), 32'd0);
            end
            if (valid_o) sawValid = 1'b1;
        end
        checkOutput("flush_no_valid", 32'(sawValid), 32'd0);
        checkOutput("flush_result_held", result_o, lastExp);
        v = '{"div_9_3_after_flush", OP_DIV, 32'd9, 32'd3, 32'd3, 34};
        applyStimulus(v);

        // A second start while busy must not disturb the running DIV 20/3.
        @(negedge clk_i);
        op_i = OP_DIV; DataA = 32'd20; DataB = 32'd3; start_i = 1'b1;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk_i);
            if (c == 1) start_i = 1'b0;
            if (c == 5) begin
                start_i = 1'b1; op_i = OP_DIVU; DataA = 32'd100; DataB = 32'd10;
            end
            if (c == 6) start_i = 1'b0;
            if (valid_o) lat = c;
        end
        checkOutput("ignore_start_latency", 32'(lat), 32'd34);
        checkOutput("ignore_start_result", result_o, 32'd6);
        @(negedge clk_i);

        // Reset mid-operation clears everything immediately.
        @(negedge clk_i);
        op_i = OP_DIVU; DataA = 32'd1000; DataB = 32'd7; start_i = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_i);
            if (c == 1) start_i = 1'b0;
        end
        rst_i = 1'b1;
        #1;
        checkOutput("midreset_busy",   32'(busy_o),  32'd0);
        checkOutput("midreset_valid",  32'(valid_o), 32'd0);
        checkOutput("midreset_result", result_o,     32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        v = '{"divu_1000_10_after_reset", OP_DIVU, 32'd1000, 32'd10, 32'd100, 34};
        applyStimulus(v);

        // Flush in the DONE cycle still shows that cycle's pulse.
        @(negedge clk_i);
        op_i = OP_DIVU; DataA = 32'd5; DataB = 32'd0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        flush_i = 1'b1;
        checkOutput("flush_done_valid",  32'(valid_o), 32'd1);
        checkOutput("flush_done_result", result_o,     32'hFFFFFFFF);
        @(negedge clk_i);
        flush_i = 1'b0;
        checkOutput("flush_done_idle", {30'd0, busy_o, valid_o}, 32'd0);

        // Flush and start together in IDLE: nothing is accepted.
        @(negedge clk_i);
        op_i = OP_DIV; DataA = 32'd20; DataB = 32'd3; start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        checkOutput("flush_start_idle",   {30'd0, busy_o, valid_o}, 32'd0);
        checkOutput("flush_start_result", result_o, 32'hFFFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
